// File: rtl/uart_mux_tx.sv
// Host-bound UART packet transmitter: sends {addr, len, len data bytes} at 8N1.
// Each bit lasts CLKS_PER_BIT clocks; consecutive frames are separated by at least
// one idle-high cycle. All outputs come straight from flops.
module uart_mux_tx #(
    parameter int unsigned CLKS_PER_BIT = 21
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pkt_start,
    input  logic [7:0] pkt_addr,
    input  logic [7:0] pkt_len,
    output logic       pkt_busy,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       uart_txd
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_STOP = IDX_W'(9);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_ADDR,
        ST_SEND_LEN,
        ST_WAIT_DATA,
        ST_SEND_DATA
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;     // clocks elapsed within the current bit
    logic [IDX_W-1:0] idx_q, idx_n;     // bit on the line: 0 start, 1..8 data, 9 stop
    logic [7:0]       byte_q, byte_n;   // byte currently being serialised
    logic [7:0]       rem_q, rem_n;     // data bytes still to send
    logic             gap_q, gap_n;     // one idle-high cycle between address and length
    logic             txd_n;
    logic             busy_n;
    logic             ready_n;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            byte_q     <= '0;
            rem_q      <= '0;
            gap_q      <= 1'b0;
            uart_txd   <= 1'b1;
            pkt_busy   <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            idx_q      <= idx_n;
            byte_q     <= byte_n;
            rem_q      <= rem_n;
            gap_q      <= gap_n;
            uart_txd   <= txd_n;
            pkt_busy   <= busy_n;
            data_ready <= ready_n;
        end
    end

    // Next-state, framing and next-output logic
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        byte_n  = byte_q;
        rem_n   = rem_q;
        gap_n   = gap_q;
        txd_n   = uart_txd;

        case (state_q)
            ST_IDLE: begin
                txd_n = 1'b1;
                if (pkt_start) begin
                    state_n = ST_SEND_ADDR;
                    byte_n  = pkt_addr;
                    rem_n   = pkt_len;
                    cnt_n   = '0;
                    idx_n   = '0;
                    gap_n   = 1'b0;
                    txd_n   = 1'b0;
                end
            end

            ST_WAIT_DATA: begin
                txd_n = 1'b1;
                if (data_valid && data_ready) begin
                    state_n = ST_SEND_DATA;
                    byte_n  = data_in;
                    cnt_n   = '0;
                    idx_n   = '0;
                    txd_n   = 1'b0;
                end
            end

            ST_SEND_ADDR, ST_SEND_LEN, ST_SEND_DATA: begin
                if (gap_q) begin
                    // idle cycle done, start bit of the length byte goes out
                    gap_n = 1'b0;
                    cnt_n = '0;
                    idx_n = '0;
                    txd_n = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_n = '0;
                    if (idx_q == IDX_STOP) begin
                        txd_n = 1'b1;
                        idx_n = '0;
                        case (state_q)
                            ST_SEND_ADDR: begin
                                state_n = ST_SEND_LEN;
                                byte_n  = rem_q;
                                gap_n   = 1'b1;
                            end
                            ST_SEND_LEN: begin
                                state_n = (rem_q != 8'd0) ? ST_WAIT_DATA : ST_IDLE;
                            end
                            default: begin
                                rem_n   = rem_q - 8'd1;
                                state_n = (rem_q == 8'd1) ? ST_IDLE : ST_WAIT_DATA;
                            end
                        endcase
                    end else begin
                        idx_n = idx_q + 4'd1;
                        if (idx_q == IDX_LAST_DATA) begin
                            txd_n = 1'b1;
                        end else begin
                            txd_n = byte_q[3'(idx_q)];
                        end
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
                txd_n   = 1'b1;
            end
        endcase

        busy_n  = (state_n != ST_IDLE);
        ready_n = (state_n == ST_WAIT_DATA);
    end

endmodule

// File: tb/tb_uart_mux_tx.sv
// Self-checking bench for uart_mux_tx with a per-cycle line model and a UART receiver model.
module tb_uart_mux_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int SLOT  = FRAME + 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pkt_start;
    logic [7:0] pkt_addr;
    logic [7:0] pkt_len;
    logic       pkt_busy;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       uart_txd;

    int total = 0;
    int bad   = 0;

    logic       tx_q[$];
    logic       busy_q[$];
    logic       rdy_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] exp_b[$];
    logic [7:0] dec_q[$];
    logic       dec_err;

    uart_mux_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pkt_start  (pkt_start),
        .pkt_addr   (pkt_addr),
        .pkt_len    (pkt_len),
        .pkt_busy   (pkt_busy),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .uart_txd   (uart_txd)
    );

    always #5 clk = ~clk;

    // Ideal line for exp_b sent back to back: 10-bit frames, one idle cycle after each.
    function automatic logic exp_line(input int i);
        int f;
        int off;
        int b;
        logic [7:0] v;
        f   = i / SLOT;
        off = i % SLOT;
        if (f >= exp_b.size() || off == FRAME) return 1'b1;
        b = off / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        v = exp_b[f];
        return v[b-1];
    endfunction

    function automatic int wave_mismatch(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) if (tx_q[i] !== exp_line(i)) m++;
        return m;
    endfunction

    function automatic int busy_len();
        foreach (busy_q[i]) if (busy_q[i] !== 1'b1) return i;
        return busy_q.size();
    endfunction

    function automatic int ready_high();
        int n = 0;
        foreach (rdy_q[i]) if (rdy_q[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int ready_rises();
        int n = 0;
        foreach (rdy_q[i]) if (rdy_q[i] === 1'b1 && (i == 0 || rdy_q[i-1] !== 1'b1)) n++;
        return n;
    endfunction

    function automatic int longest_ready();
        int run = 0;
        int best = 0;
        foreach (rdy_q[i]) begin
            run = (rdy_q[i] === 1'b1) ? run + 1 : 0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    function automatic int dec_mismatch();
        int n = 0;
        if (dec_err) n++;
        if (dec_q.size() != exp_b.size()) return n + 1000;
        foreach (exp_b[i]) if (dec_q[i] !== exp_b[i]) n++;
        return n;
    endfunction

    // Receiver model: find start edges and sample every bit at mid-point.
    task automatic decode();
        int i = 0;
        dec_q.delete();
        dec_err = 1'b0;
        while (i + FRAME <= tx_q.size()) begin
            if (tx_q[i] === 1'b0 && (i == 0 || tx_q[i-1] === 1'b1)) begin
                logic [7:0] b;
                for (int j = 0; j < 8; j++) b[j] = tx_q[i + (j + 1) * CPB + CPB / 2];
                if (tx_q[i + CPB / 2] !== 1'b0 || tx_q[i + 9 * CPB + CPB / 2] !== 1'b1) dec_err = 1'b1;
                dec_q.push_back(b);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    // Starts a packet and records the outputs for ncyc cycles beginning with the start bit.
    // The producer offers pl_q in order; after byte stall_at-1 it withholds data stall_len cycles.
    task automatic capture(input logic [7:0] addr, input logic [7:0] len, input int ncyc,
                           input int stall_at, input int stall_len, input int poke_at,
                           input int rst_at);
        int   k = 0;
        int   hold = 0;
        logic acc;
        logic poke = 1'b0;
        logic drop;
        tx_q.delete();
        busy_q.delete();
        rdy_q.delete();
        @(posedge clk); #1;
        pkt_start = 1'b1;
        pkt_addr  = addr;
        pkt_len   = len;
        @(posedge clk); #1;
        pkt_start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (c == poke_at) begin
                pkt_start = 1'b1;
                pkt_addr  = 8'h41;
                pkt_len   = 8'h00;
                poke      = 1'b1;
            end
            reset_n = (c == rst_at) ? 1'b0 : 1'b1;
            if (k < pl_q.size() && hold == 0) begin
                data_valid = 1'b1;
                data_in    = pl_q[k];
            end else begin
                data_valid = 1'b0;
                data_in    = 8'($urandom);
            end
            @(negedge clk);
            tx_q.push_back(uart_txd);
            busy_q.push_back(pkt_busy);
            rdy_q.push_back(data_ready);
            acc  = data_valid && data_ready;
            drop = poke && !pkt_busy;
            @(posedge clk); #1;
            if (drop) begin
                pkt_start = 1'b0;
                poke      = 1'b0;
            end
            if (hold > 0) hold--;
            if (acc) begin
                k++;
                if (k == stall_at) hold = stall_len;
            end
        end
        data_valid = 1'b0;
        reset_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        pkt_start  = 1'b0;
        pkt_addr   = 8'h00;
        pkt_len    = 8'h00;
        data_valid = 1'b1;
        data_in    = 8'h5A;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (uart_txd !== 1'b1) begin bad++; $display("FAIL rst_txd: got %b want 1", uart_txd); end
        total++;
        if (pkt_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", pkt_busy); end
        total++;
        if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", data_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({uart_txd, pkt_busy, data_ready} !== 3'b100)
            begin bad++; $display("FAIL idle_valid_ignored: got txd/busy/ready=%b want 100",
                                  {uart_txd, pkt_busy, data_ready}); end
        data_valid = 1'b0;
    endtask

    task automatic test_header_only();
        int n;
        pl_q.delete();
        exp_b = '{8'h37, 8'h00};
        data_valid = 1'b1;   // offered with pkt_start in IDLE; must not be taken
        data_in    = 8'hAB;
        capture(8'h37, 8'h00, 100, -1, 0, -1, -1);
        n = wave_mismatch(100);
        total++;
        if (n !== 0) begin bad++; $display("FAIL hdr_wave: got %0d bad cycles want 0", n); end
        n = busy_len();
        total++;
        if (n !== 2 * SLOT - 1) begin bad++; $display("FAIL hdr_busy_len: got %0d want %0d", n, 2 * SLOT - 1); end
        n = ready_high();
        total++;
        if (n !== 0) begin bad++; $display("FAIL hdr_ready: got %0d high cycles want 0", n); end
        decode();
        n = dec_mismatch();
        total++;
        if (n !== 0) begin bad++; $display("FAIL hdr_decode: got %0d bytes, %0d errors; want %0d bytes, 0 errors", dec_q.size(), n, exp_b.size()); end
    endtask

    task automatic test_immediate_data();
        int n;
        pl_q  = '{8'hA5, 8'h01, 8'hFF};
        exp_b = '{8'h40, 8'h03, 8'hA5, 8'h01, 8'hFF};
        capture(8'h40, 8'h03, 215, -1, 0, -1, -1);
        n = wave_mismatch(215);
        total++;
        if (n !== 0) begin bad++; $display("FAIL imm_wave: got %0d bad cycles want 0", n); end
        n = busy_len();
        total++;
        if (n !== 5 * SLOT - 1) begin bad++; $display("FAIL imm_busy_len: got %0d want %0d", n, 5 * SLOT - 1); end
        n = ready_high();
        total++;
        if (n !== 3) begin bad++; $display("FAIL imm_ready_cycles: got %0d want 3", n); end
        n = ready_rises();
        total++;
        if (n !== 3) begin bad++; $display("FAIL imm_ready_pulses: got %0d want 3", n); end
        decode();
        n = dec_mismatch();
        total++;
        if (n !== 0) begin bad++; $display("FAIL imm_decode: got %0d bytes, %0d errors; want %0d bytes, 0 errors", dec_q.size(), n, exp_b.size()); end
    endtask

    task automatic test_stall();
        int n;
        int run_exp;
        int lowline = 0;
        // producer is silent 100 cycles after byte 0; its frame fills the first FRAME of them
        run_exp = 100 - FRAME + 1;
        pl_q  = '{8'hA5, 8'h01, 8'hFF};
        exp_b = '{8'h40, 8'h03, 8'hA5, 8'h01, 8'hFF};
        capture(8'h40, 8'h03, 330, 1, 100, -1, -1);
        n = longest_ready();
        total++;
        if (n !== run_exp) begin bad++; $display("FAIL stall_ready_run: got %0d want %0d", n, run_exp); end
        n = ready_high();
        total++;
        if (n !== run_exp + 2) begin bad++; $display("FAIL stall_ready_cycles: got %0d want %0d", n, run_exp + 2); end
        foreach (rdy_q[i]) if (rdy_q[i] === 1'b1 && tx_q[i] !== 1'b1) lowline++;
        total++;
        if (lowline !== 0) begin bad++; $display("FAIL stall_line_high: got %0d low cycles while ready want 0", lowline); end
        n = busy_len();
        total++;
        if (n !== 5 * SLOT - 1 + run_exp - 1) begin bad++; $display("FAIL stall_busy_len: got %0d want %0d", n, 5 * SLOT - 2 + run_exp); end
        decode();
        n = dec_mismatch();
        total++;
        if (n !== 0) begin bad++; $display("FAIL stall_decode: got %0d bytes, %0d errors; want %0d bytes, 0 errors", dec_q.size(), n, exp_b.size()); end
    endtask

    task automatic test_ignore_start();
        int n;
        int bm = 0;
        pl_q  = '{8'h22};
        // the mid-packet request is dropped; the one held into the IDLE cycle starts packet two
        exp_b = '{8'h10, 8'h01, 8'h22, 8'h41, 8'h00};
        capture(8'h10, 8'h01, 230, -1, 0, 50, -1);
        n = wave_mismatch(230);
        total++;
        if (n !== 0) begin bad++; $display("FAIL ign_wave: got %0d bad cycles want 0", n); end
        foreach (busy_q[i]) if (busy_q[i] !== ((i < 5 * SLOT - 1) && (i != 3 * SLOT - 1))) bm++;
        total++;
        if (bm !== 0) begin bad++; $display("FAIL ign_busy: got %0d bad cycles want 0", bm); end
        decode();
        n = dec_mismatch();
        total++;
        if (n !== 0) begin bad++; $display("FAIL ign_decode: got %0d bytes, %0d errors; want %0d bytes, 0 errors", dec_q.size(), n, exp_b.size()); end
    endtask

    task automatic test_reset_mid();
        int rst_at;
        int viol = 0;
        // first data frame starts at 2*SLOT; reset lands in the second cycle of its bit 4
        rst_at = 2 * SLOT + 4 * CPB + 1;
        pl_q = '{8'hC3, 8'h3C};
        capture(8'h55, 8'h02, 300, -1, 0, -1, rst_at);
        total++;
        if ({tx_q[rst_at], busy_q[rst_at]} !== 2'b01)
            begin bad++; $display("FAIL rmid_before: got txd/busy=%b want 01", {tx_q[rst_at], busy_q[rst_at]}); end
        total++;
        if (tx_q[rst_at+1] !== 1'b1) begin bad++; $display("FAIL rmid_txd: got %b want 1", tx_q[rst_at+1]); end
        total++;
        if (busy_q[rst_at+1] !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy_q[rst_at+1]); end
        total++;
        if (rdy_q[rst_at+1] !== 1'b0) begin bad++; $display("FAIL rmid_ready: got %b want 0", rdy_q[rst_at+1]); end
        for (int i = rst_at + 1; i < tx_q.size(); i++)
            if (tx_q[i] !== 1'b1 || busy_q[i] !== 1'b0 || rdy_q[i] !== 1'b0) viol++;
        total++;
        if (viol !== 0) begin bad++; $display("FAIL rmid_residual: got %0d non-idle cycles want 0", viol); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 20; p++) begin
            int len;
            int st_at;
            int st_len;
            int extra;
            int ncyc;
            int n;
            logic [7:0] addr;
            len    = $urandom_range(0, 6);
            addr   = 8'($urandom);
            st_at  = (len >= 2) ? $urandom_range(1, len - 1) : -1;
            st_len = $urandom_range(0, 80);
            extra  = (st_at > 0 && st_len > FRAME) ? st_len - FRAME : 0;
            pl_q.delete();
            for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
            exp_b = '{addr, 8'(len)};
            foreach (pl_q[i]) exp_b.push_back(pl_q[i]);
            ncyc = (len + 2) * SLOT + extra + 8;
            capture(addr, 8'(len), ncyc, st_at, st_len, -1, -1);
            decode();
            n = dec_mismatch();
            total++;
            if (n !== 0) begin bad++; $display("FAIL rnd_decode[%0d]: got %0d bytes, %0d errors; want %0d bytes, 0 errors", p, dec_q.size(), n, exp_b.size()); end
            n = busy_len();
            total++;
            if (n !== (len + 2) * SLOT - 1 + extra)
                begin bad++; $display("FAIL rnd_busy_len[%0d]: got %0d want %0d", p, n, (len + 2) * SLOT - 1 + extra); end
            n = ready_high();
            total++;
            if (n !== len + extra) begin bad++; $display("FAIL rnd_ready[%0d]: got %0d want %0d", p, n, len + extra); end
            if (extra == 0) begin
                n = wave_mismatch(ncyc);
                total++;
                if (n !== 0) begin bad++; $display("FAIL rnd_wave[%0d]: got %0d bad cycles want 0", p, n); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_header_only();
        test_immediate_data();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
